indication_output_queue: RTL
============================

Name: indication_output_queue

Overview:
Parametrised successor to the two-entry ping-pong indication serializer. It accepts indication calls on NUM_METHODS independent method ports. Each call is tagged with its method index and stored in a DEPTH-entry circular queue. Entries drain in order onto a single pipe$enq port as {v, meth, tag} words. It sits between the user indication interface and the host-bound message pipe.

Parameters:
NUM_METHODS, 2, number of indication method ports (1..8)
ARG_WIDTH, 32, width of each method argument (meth, v)
TAG_WIDTH, 32, width of the tag field in the output word
DEPTH, 4, queue entries; power of two; DEPTH >= NUM_METHODS

Ports:
CLK  input  1  clock; all state updates on the rising edge
RST  input  1  reset; synchronous, active-high
indication$call__ENA  input  NUM_METHODS  per-method call strobe; bit i = method i
indication$call$meth  input  NUM_METHODS*ARG_WIDTH  meth argument; slice i belongs to method i
indication$call$v  input  NUM_METHODS*ARG_WIDTH  v argument; slice i belongs to method i
indication$call__RDY  output  NUM_METHODS  per-method ready
pipe$enq__ENA  output  1  output word valid
pipe$enq$v  output  2*ARG_WIDTH+TAG_WIDTH  {v, meth, tag}, with tag in the LSBs
pipe$enq__RDY  input  1  downstream ready
count  output  clog2(DEPTH)+1  current occupancy, for status and debug

Behaviour:
- State:
  - mem[DEPTH] of {v, meth, tag}
  - head and tail pointers, each clog2(DEPTH) bits, wrapping modulo DEPTH
  - count register
- Reset (RST=1 at an edge): head=0, tail=0, count=0. Entry contents are don't-care. Reset overrides any simultaneous push or pop.
- Outputs during and after reset: pipe$enq__ENA=0; all indication$call__RDY bits = 1 (when DEPTH >= NUM_METHODS).
- Ready rule:
  - indication$call__RDY[i] = (count <= DEPTH - NUM_METHODS), the same value for every i.
  - RDY is a function of registered state only. It never depends on any ENA input.
- Push:
  - Method i is accepted when ENA[i] & RDY[i].
  - All accepted methods in a cycle are written in ascending index order to tail, tail+1, ... (mod DEPTH).
  - Each accepted entry stores tag = i+1, zero-extended to TAG_WIDTH, together with that method's meth and v.
  - tail advances by npush, the popcount of accepted calls.
  - An ENA with RDY=0 is ignored; the caller must not assert it.
- Pop:
  - pipe$enq__ENA = (count != 0).
  - pipe$enq$v = mem[head], driven combinationally from registers. It is stable while ENA=1 and RDY=0.
  - A pop occurs when pipe$enq__ENA & pipe$enq__RDY; head then advances by 1 (mod DEPTH).
- Count update: count_next = count + npush - pop. Push and pop in the same cycle are legal, including from count=0 (the popped entry is the old head only).
- Latency: an entry pushed at edge t appears on pipe$enq at the output in the following cycle, at the earliest. There is no bypass from input to output.
- Ordering: FIFO across cycles. Within one cycle, lower method index is older.
- Boundary conditions:
  - Empty: pipe$enq__ENA=0 and the pipe$enq$v value is don't-care.
  - Full: count=DEPTH means RDY=0 for all methods.
  - Wrap-around: pointers wrap silently.
  - Overflow and underflow are impossible by construction. The bench checks them with assertions: count never exceeds DEPTH and never goes below 0.
- Width rules: ARG_WIDTH slices are taken LSB-first, so slice i = bits [i*ARG_WIDTH +: ARG_WIDTH].

Decomposition:
- Shared package (indication_pkg):
  - entry struct {v, meth, tag}
  - function tag_of(index) returning index+1
  - pointer-width and count-width localparam helpers
- One natural sub-module: indication_ring_fifo, a multi-push (up to NUM_METHODS per cycle), single-pop circular buffer with count.
- The top level holds the tag insertion and ready computation.

Test Plan:
1. Reset and single call. Apply RST for 2 cycles, release; pulse ENA=2'b01 with meth=0x5, v=0xAA, pipe RDY=1. Required: output {0xAA, 0x5, 0x1} at the next cycle, then pipe$enq__ENA drops to 0 and count returns to 0.
2. Simultaneous calls. Pulse ENA=2'b11 once with method0 (1,10) and method1 (2,20). Required: two words in order, tag 1 then tag 2; count goes 0→2→1→0.
3. Full and backpressure (DEPTH=4, NUM_METHODS=2). Hold pipe RDY=0 and push until count=3. Required: RDY=0 at count=3; pipe$enq$v holds the first word unchanged; no entry is lost when RDY returns to 1.
4. Wrap-around. Stream 11 single calls with pipe RDY=1 every other cycle. Required: all 11 words emerge in order with correct tags; the pointers have wrapped at least twice.
5. Push and pop in the same cycle. At count=1, assert ENA=2'b10 and pipe RDY=1. Required: count stays 1; the next word is the newly pushed tag-2 entry.
6. Reset mid-operation. At count=3, assert RST together with ENA and pipe RDY. Required: on the next cycle count=0 and pipe$enq__ENA=0; no stale word is emitted after reset.

Source files
------------

// File: rtl/indication_pkg.sv
// Shared types and sizing helpers for the indication output queue.
package indication_pkg;

  localparam int ARG_WIDTH_DEFAULT = 32;
  localparam int TAG_WIDTH_DEFAULT = 32;

  // Output word layout in the default configuration: tag sits in the LSBs.
  typedef struct packed {
    logic [ARG_WIDTH_DEFAULT-1:0] v;
    logic [ARG_WIDTH_DEFAULT-1:0] meth;
    logic [TAG_WIDTH_DEFAULT-1:0] tag;
  } entry_t;

  // Tag carried by a call on method port 'index'; zero is never a valid tag.
  function automatic int tag_of(input int index);
    return index + 1;
  endfunction

  // Pointer width; at least one bit so a single-entry queue still has a pointer.
  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy width; must hold the value 'depth' itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/indication_ring_fifo.sv
// Circular buffer accepting up to NPUSH writes per cycle (ascending slot order)
// and at most one read per cycle. Head entry is presented straight from storage.
module indication_ring_fifo
  import indication_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 96,
  parameter int NPUSH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NPUSH-1:0]              push_en,
  input  logic [NPUSH*WIDTH-1:0]        push_data,
  input  logic                          pop,
  output logic [WIDTH-1:0]              head_data,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int PTR_W = ptr_width(DEPTH);
  localparam int CNT_W = cnt_width(DEPTH);
  // One extra bit so pointer + push count never overflows before the wrap.
  localparam int SUM_W = CNT_W + 1;
  localparam logic [SUM_W-1:0] DEPTH_S = SUM_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] npush_s;
  logic [SUM_W-1:0] slot_s;

  // Pack accepted writes into consecutive slots from tail and advance pointers.
  always_comb begin
    mem_d   = mem_q;
    npush_s = '0;
    slot_s  = '0;
    for (int i = 0; i < NPUSH; i++) begin
      if (push_en[i]) begin
        slot_s = (SUM_W'(tail_q) + SUM_W'(npush_s)) % DEPTH_S;
        mem_d[slot_s[PTR_W-1:0]] = push_data[i*WIDTH +: WIDTH];
        npush_s = npush_s + CNT_W'(1'b1);
      end else begin
        npush_s = npush_s;
      end
    end
    tail_d  = PTR_W'((SUM_W'(tail_q) + SUM_W'(npush_s)) % DEPTH_S);
    head_d  = PTR_W'((SUM_W'(head_q) + SUM_W'(pop)) % DEPTH_S);
    count_d = count_q + npush_s - CNT_W'(pop);
  end

  // Pointer and occupancy registers; reset wins over any same-cycle push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[head_q];
  assign count     = count_q;

endmodule

// File: rtl/indication_output_queue.sv
// Serialises indication calls from NUM_METHODS ports into one {v, meth, tag}
// message stream, tagging each call with its method index plus one.
module indication_output_queue
  import indication_pkg::*;
#(
  parameter int NUM_METHODS = 2,
  parameter int ARG_WIDTH   = 32,
  parameter int TAG_WIDTH   = 32,
  parameter int DEPTH       = 4
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [NUM_METHODS-1:0]             indication_call__ENA,
  input  logic [NUM_METHODS*ARG_WIDTH-1:0]   indication_call_meth,
  input  logic [NUM_METHODS*ARG_WIDTH-1:0]   indication_call_v,
  output logic [NUM_METHODS-1:0]             indication_call__RDY,
  output logic                               pipe_enq__ENA,
  output logic [2*ARG_WIDTH+TAG_WIDTH-1:0]   pipe_enq_v,
  input  logic                               pipe_enq__RDY,
  output logic [cnt_width(DEPTH)-1:0]        count
);

  localparam int CNT_W  = cnt_width(DEPTH);
  localparam int WORD_W = 2*ARG_WIDTH + TAG_WIDTH;
  // Worst case every method calls at once, so leave NUM_METHODS free slots.
  localparam logic [CNT_W-1:0] RDY_LIMIT = CNT_W'(DEPTH - NUM_METHODS);

  logic                          rdy_s;
  logic                          nonempty_s;
  logic                          pop_s;
  logic [NUM_METHODS-1:0]        accept_s;
  logic [NUM_METHODS*WORD_W-1:0] push_data_s;
  logic [WORD_W-1:0]             head_s;
  logic [CNT_W-1:0]              count_s;

  // Ready depends on occupancy only, never on this cycle's call strobes.
  always_comb begin
    rdy_s      = (count_s <= RDY_LIMIT);
    accept_s   = indication_call__ENA & {NUM_METHODS{rdy_s}};
    nonempty_s = (count_s != '0);
    pop_s      = nonempty_s & pipe_enq__RDY;
  end

  // Build each method's candidate word with its fixed tag in the LSBs.
  always_comb begin
    push_data_s = '0;
    for (int i = 0; i < NUM_METHODS; i++) begin
      push_data_s[i*WORD_W +: WORD_W] = {indication_call_v[i*ARG_WIDTH +: ARG_WIDTH],
                                         indication_call_meth[i*ARG_WIDTH +: ARG_WIDTH],
                                         TAG_WIDTH'(tag_of(i))};
    end
  end

  indication_ring_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W),
    .NPUSH (NUM_METHODS)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push_en   (accept_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (count_s)
  );

  assign indication_call__RDY = {NUM_METHODS{rdy_s}};
  assign pipe_enq__ENA        = nonempty_s;
  assign pipe_enq_v           = head_s;
  assign count                = count_s;

endmodule
